// File: rtl/risc_v_isa_pkg.sv
// RV32I encoding types, decoded-instruction record and the reference decode function
// shared by the decode stage and anything downstream that consumes instrInfo_s.
package risc_v_isa_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {ALU, MEM, BRN, JMP, LUP, ENV} unit_e;
  typedef enum logic [3:0] {ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND} aluOp_e;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} decState_e;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rType_s;

  typedef struct packed {
    logic [11:0] imm_11_0;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } iType_s;

  typedef struct packed {
    logic [6:0] imm_11_5;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] imm_4_0;
    logic [6:0] opcode;
  } sType_s;

  typedef struct packed {
    logic       imm_12;
    logic [5:0] imm_10_5;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [3:0] imm_4_1;
    logic       imm_11;
    logic [6:0] opcode;
  } bType_s;

  typedef struct packed {
    logic [19:0] imm_31_12;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } uType_s;

  typedef struct packed {
    logic       imm_20;
    logic [9:0] imm_10_1;
    logic       imm_11;
    logic [7:0] imm_19_12;
    logic [4:0] rd;
    logic [6:0] opcode;
  } jType_s;

  typedef union packed {
    logic [31:0] raw;
    rType_s      r;
    iType_s      i;
    sType_s      s;
    bType_s      b;
    uType_s      u;
    jType_s      j;
  } instr_u;

  // Fields a unit does not use keep their NOP values; op_size carries funct3 for MEM and BRN.
  typedef struct packed {
    unit_e       unit;
    aluOp_e      alu_op;
    logic        use_immediate;
    logic        use_src_reg;
    logic        incr_pc;
    logic        is_call;
    logic        is_break;
    logic        mem_write;
    logic [2:0]  op_size;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } instrInfo_s;

  typedef struct packed {
    instrInfo_s info;
    logic       illegal;
  } decResult_s;

  localparam instrInfo_s NOP_INSTR_INFO = '{
    unit:          ALU,
    alu_op:        ADD,
    use_immediate: 1'b1,
    use_src_reg:   1'b0,
    incr_pc:       1'b0,
    is_call:       1'b0,
    is_break:      1'b0,
    mem_write:     1'b0,
    op_size:       3'd0,
    rd:            5'd0,
    rs1:           5'd0,
    rs2:           5'd0,
    imm:           32'd0
  };

  function automatic decResult_s decode_instr(instr_u instr);
    decResult_s res;
    res.info    = NOP_INSTR_INFO;
    res.illegal = 1'b0;
    case (instr.r.opcode)
      OPC_OP: begin
        res.info.use_immediate = 1'b0;
        res.info.rd            = instr.r.rd;
        res.info.rs1           = instr.r.rs1;
        res.info.rs2           = instr.r.rs2;
        case ({instr.r.funct7, instr.r.funct3})
          {7'h00, 3'b000}: res.info.alu_op = ADD;
          {7'h20, 3'b000}: res.info.alu_op = SUB;
          {7'h00, 3'b001}: res.info.alu_op = SLL;
          {7'h00, 3'b010}: res.info.alu_op = SLT;
          {7'h00, 3'b011}: res.info.alu_op = SLTU;
          {7'h00, 3'b100}: res.info.alu_op = XOR;
          {7'h00, 3'b101}: res.info.alu_op = SRL;
          {7'h20, 3'b101}: res.info.alu_op = SRA;
          {7'h00, 3'b110}: res.info.alu_op = OR;
          {7'h00, 3'b111}: res.info.alu_op = AND;
          default:         res.illegal     = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        res.info.rd  = instr.i.rd;
        res.info.rs1 = instr.i.rs1;
        res.info.imm = {{20{instr.i.imm_11_0[11]}}, instr.i.imm_11_0};
        case (instr.i.funct3)
          3'b000: res.info.alu_op = ADD;
          3'b010: res.info.alu_op = SLT;
          3'b011: res.info.alu_op = SLTU;
          3'b100: res.info.alu_op = XOR;
          3'b110: res.info.alu_op = OR;
          3'b111: res.info.alu_op = AND;
          3'b001: begin
            res.info.alu_op = SLL;
            res.info.imm    = {27'd0, instr.r.rs2};
            res.illegal     = (instr.r.funct7 != 7'h00);
          end
          default: begin
            res.info.alu_op = (instr.r.funct7 == 7'h20) ? SRA : SRL;
            res.info.imm    = {27'd0, instr.r.rs2};
            res.illegal     = (instr.r.funct7 != 7'h00) && (instr.r.funct7 != 7'h20);
          end
        endcase
      end
      OPC_LOAD: begin
        res.info.unit    = MEM;
        res.info.op_size = instr.i.funct3;
        res.info.rd      = instr.i.rd;
        res.info.rs1     = instr.i.rs1;
        res.info.imm     = {{20{instr.i.imm_11_0[11]}}, instr.i.imm_11_0};
        res.illegal      = (instr.i.funct3 == 3'd3) || (instr.i.funct3 >= 3'd6);
      end
      OPC_STORE: begin
        res.info.unit      = MEM;
        res.info.mem_write = 1'b1;
        res.info.op_size   = instr.s.funct3;
        res.info.rs1       = instr.s.rs1;
        res.info.rs2       = instr.s.rs2;
        res.info.imm       = {{20{instr.s.imm_11_5[6]}}, instr.s.imm_11_5, instr.s.imm_4_0};
        res.illegal        = (instr.s.funct3 > 3'd2);
      end
      OPC_BRANCH: begin
        res.info.unit    = BRN;
        res.info.op_size = instr.b.funct3;
        res.info.rs1     = instr.b.rs1;
        res.info.rs2     = instr.b.rs2;
        res.info.imm     = {{19{instr.b.imm_12}}, instr.b.imm_12, instr.b.imm_11,
                            instr.b.imm_10_5, instr.b.imm_4_1, 1'b0};
        res.illegal      = (instr.b.funct3 == 3'd2) || (instr.b.funct3 == 3'd3);
      end
      OPC_JAL: begin
        res.info.unit = JMP;
        res.info.rd   = instr.j.rd;
        res.info.imm  = {{11{instr.j.imm_20}}, instr.j.imm_20, instr.j.imm_19_12,
                         instr.j.imm_11, instr.j.imm_10_1, 1'b0};
      end
      OPC_JALR: begin
        res.info.unit        = JMP;
        res.info.use_src_reg = 1'b1;
        res.info.rd          = instr.i.rd;
        res.info.rs1         = instr.i.rs1;
        res.info.imm         = {{20{instr.i.imm_11_0[11]}}, instr.i.imm_11_0};
      end
      OPC_LUI, OPC_AUIPC: begin
        res.info.unit    = LUP;
        res.info.incr_pc = (instr.u.opcode == OPC_AUIPC);
        res.info.rd      = instr.u.rd;
        res.info.imm     = {instr.u.imm_31_12, 12'd0};
      end
      OPC_SYSTEM: begin
        res.info.unit     = ENV;
        res.info.is_call  = (instr.i.imm_11_0 == 12'd0);
        res.info.is_break = (instr.i.imm_11_0 == 12'd1);
        res.illegal       = (instr.i.imm_11_0 > 12'd1);
      end
      default: res.illegal = 1'b1;
    endcase
    if (res.illegal) res.info = NOP_INSTR_INFO;
    return res;
  endfunction

endpackage

// File: rtl/instr_decode_comb.sv
// Purely combinational RV32I decode: raw word in, decoded record and illegal flag out.
module instr_decode_comb
  import risc_v_isa_pkg::*;
#(
  parameter bit CHECK_ILLEGAL = 1'b1
) (
  input  instr_u     instr_i,
  output instrInfo_s info_o,
  output logic       illegal_o
);

  decResult_s res;

  always_comb begin
    res       = decode_instr(instr_i);
    info_o    = res.info;
    illegal_o = CHECK_ILLEGAL ? res.illegal : 1'b0;
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered RV32I decode stage with a 2-entry skid buffer between fetch and execute.
// Decode happens before the register so the skid slot stores already-decoded entries.
module instr_decode_stage
  import risc_v_isa_pkg::*;
#(
  parameter int unsigned PC_WIDTH      = 12,
  parameter bit          CHECK_ILLEGAL = 1'b1
) (
  input  logic                clk_in,
  input  logic                rst_low_in,
  input  logic                flush_in,
  input  logic                instr_valid_in,
  output logic                instr_ready_out,
  input  instr_u              raw_instr_in,
  input  logic [PC_WIDTH-1:0] instr_pc_in,
  output logic                dec_valid_out,
  input  logic                dec_ready_in,
  output instrInfo_s          dec_instr_out,
  output logic [PC_WIDTH-1:0] dec_pc_out,
  output logic                dec_illegal_out
);

  decState_e           state_q, state_d;
  instrInfo_s          main_info_q, main_info_d, skid_info_q, skid_info_d;
  logic [PC_WIDTH-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic                main_ill_q, main_ill_d, skid_ill_q, skid_ill_d;

  instrInfo_s new_info;
  logic       new_illegal;
  logic       in_fire, out_fire;

  instr_decode_comb #(
    .CHECK_ILLEGAL(CHECK_ILLEGAL)
  ) u_decode (
    .instr_i  (raw_instr_in),
    .info_o   (new_info),
    .illegal_o(new_illegal)
  );

  assign instr_ready_out = (state_q != TWO);
  assign dec_valid_out   = (state_q != EMPTY);
  assign dec_instr_out   = main_info_q;
  assign dec_pc_out      = main_pc_q;
  assign dec_illegal_out = main_ill_q;

  assign in_fire  = instr_valid_in & instr_ready_out;
  assign out_fire = dec_valid_out & dec_ready_in;

  always_comb begin
    state_d     = state_q;
    main_info_d = main_info_q;
    main_pc_d   = main_pc_q;
    main_ill_d  = main_ill_q;
    skid_info_d = skid_info_q;
    skid_pc_d   = skid_pc_q;
    skid_ill_d  = skid_ill_q;
    if (flush_in) begin
      state_d     = EMPTY;
      main_info_d = NOP_INSTR_INFO;
      main_pc_d   = '0;
      main_ill_d  = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d     = ONE;
            main_info_d = new_info;
            main_pc_d   = instr_pc_in;
            main_ill_d  = new_illegal;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_info_d = new_info;
            main_pc_d   = instr_pc_in;
            main_ill_d  = new_illegal;
          end else if (in_fire) begin
            // Main slot is stalled; park the new word behind it.
            state_d     = TWO;
            skid_info_d = new_info;
            skid_pc_d   = instr_pc_in;
            skid_ill_d  = new_illegal;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d     = ONE;
            main_info_d = skid_info_q;
            main_pc_d   = skid_pc_q;
            main_ill_d  = skid_ill_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_low_in) begin
    if (!rst_low_in) begin
      state_q     <= EMPTY;
      main_info_q <= NOP_INSTR_INFO;
      main_pc_q   <= '0;
      main_ill_q  <= 1'b0;
      skid_info_q <= NOP_INSTR_INFO;
      skid_pc_q   <= '0;
      skid_ill_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_info_q <= main_info_d;
      main_pc_q   <= main_pc_d;
      main_ill_q  <= main_ill_d;
      skid_info_q <= skid_info_d;
      skid_pc_q   <= skid_pc_d;
      skid_ill_q  <= skid_ill_d;
    end
  end

endmodule
